// File: rtl/lane_judge_ctrl.sv
// Multi-lane rhythm-game controller: sequences clear/draw/wait/judge per row and
// keeps score, streak, lives and scroll offset for the VGA drawer.
module lane_judge_ctrl #(
    parameter int LANES      = 3,
    parameter int ROWS       = 8,
    parameter int ROW_CYCLES = 16,
    parameter int SCORE_W    = 8,
    parameter int LIVES      = 3,
    parameter int FREE_PLAY  = 0
) (
    input  logic                         clock,
    input  logic                         reset,
    input  logic                         start,
    input  logic                         clear_done,
    input  logic                         draw_done,
    input  logic [LANES-1:0]             key,
    input  logic [LANES-1:0]             note_row,
    output logic                         clear_go,
    output logic                         draw_go,
    output logic [$clog2(ROWS)-1:0]      row_offset,
    output logic [SCORE_W-1:0]           score,
    output logic [SCORE_W-1:0]           streak,
    output logic [$clog2(LIVES+1)-1:0]   lives,
    output logic [LANES-1:0]             hit_flags,
    output logic                         miss_flag,
    output logic                         game_over,
    output logic [2:0]                   state_dbg
);

    localparam int RW = $clog2(ROWS);
    localparam int LW = $clog2(LIVES + 1);
    localparam int WW = (ROW_CYCLES > 1) ? $clog2(ROW_CYCLES) : 1;
    localparam int SW = SCORE_W + $clog2(LANES + 1) + 1;

    localparam logic [SCORE_W-1:0] SCORE_MAX  = '1;
    localparam logic [WW-1:0]      WAIT_LAST  = WW'(ROW_CYCLES - 1);
    localparam logic [RW-1:0]      ROW_LAST   = RW'(ROWS - 1);
    localparam logic [LW-1:0]      LIVES_INIT = LW'(LIVES);

    // Valid/ready: clear_go and draw_go are requests held high until the drawer
    // answers with a single-cycle clear_done/draw_done; answers in other states are ignored.
    typedef enum logic [2:0] {
        S_IDLE    = 3'd0,
        S_CLEAR   = 3'd1,
        S_DRAW    = 3'd2,
        S_WAIT    = 3'd3,
        S_JUDGE   = 3'd4,
        S_ADVANCE = 3'd5,
        S_OVER    = 3'd6
    } state_t;

    state_t             state_q, state_d;
    logic [SCORE_W-1:0] score_q, score_d;
    logic [SCORE_W-1:0] streak_q, streak_d;
    logic [LW-1:0]      lives_q, lives_d;
    logic [RW-1:0]      row_offset_q, row_offset_d;
    logic [LANES-1:0]   key_latch_q, key_latch_d;
    logic [WW-1:0]      wait_cnt_q, wait_cnt_d;
    logic [LANES-1:0]   hit_flags_q, hit_flags_d;
    logic               miss_flag_q, miss_flag_d;

    logic [LANES-1:0]   hits;
    logic               bad;
    logic [SW-1:0]      score_sum;

    function automatic logic [SW-1:0] count_hits(input logic [LANES-1:0] v);
        logic [SW-1:0] cnt;
        cnt = '0;
        for (int i = 0; i < LANES; i++) begin
            if (v[i]) cnt = cnt + SW'(1);
        end
        return cnt;
    endfunction

    always_comb begin
        state_d      = state_q;
        score_d      = score_q;
        streak_d     = streak_q;
        lives_d      = lives_q;
        row_offset_d = row_offset_q;
        key_latch_d  = key_latch_q;
        wait_cnt_d   = wait_cnt_q;
        hit_flags_d  = '0;
        miss_flag_d  = 1'b0;

        hits      = key_latch_q & note_row;
        bad       = |(note_row ^ key_latch_q);
        score_sum = SW'(score_q) + count_hits(hits);

        case (state_q)
            S_IDLE: begin
                if (start) state_d = S_CLEAR;
            end
            S_CLEAR: begin
                score_d      = '0;
                streak_d     = '0;
                lives_d      = LIVES_INIT;
                row_offset_d = '0;
                key_latch_d  = '0;
                wait_cnt_d   = '0;
                if (clear_done) state_d = S_DRAW;
            end
            S_DRAW: begin
                key_latch_d = key_latch_q | key;
                wait_cnt_d  = '0;
                if (draw_done) state_d = S_WAIT;
            end
            S_WAIT: begin
                key_latch_d = key_latch_q | key;
                if (wait_cnt_q == WAIT_LAST) state_d = S_JUDGE;
                else wait_cnt_d = wait_cnt_q + WW'(1);
            end
            S_JUDGE: begin
                hit_flags_d = hits;
                miss_flag_d = bad;
                if (!bad) begin
                    score_d  = (score_sum > SW'(SCORE_MAX)) ? SCORE_MAX : score_sum[SCORE_W-1:0];
                    streak_d = (streak_q == SCORE_MAX) ? streak_q : streak_q + SCORE_W'(1);
                end else begin
                    streak_d = '0;
                    if (FREE_PLAY == 0 && lives_q != '0) lives_d = lives_q - LW'(1);
                end
                state_d = (lives_d == '0) ? S_OVER : S_ADVANCE;
            end
            S_ADVANCE: begin
                // A key pressed during the advance cycle belongs to the next row.
                row_offset_d = (row_offset_q == ROW_LAST) ? '0 : row_offset_q + RW'(1);
                key_latch_d  = key;
                state_d      = S_DRAW;
            end
            S_OVER: begin
                if (start) state_d = S_CLEAR;
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clock) begin
        if (!reset) begin
            state_q      <= S_IDLE;
            score_q      <= '0;
            streak_q     <= '0;
            lives_q      <= LIVES_INIT;
            row_offset_q <= '0;
            key_latch_q  <= '0;
            wait_cnt_q   <= '0;
            hit_flags_q  <= '0;
            miss_flag_q  <= 1'b0;
        end else begin
            state_q      <= state_d;
            score_q      <= score_d;
            streak_q     <= streak_d;
            lives_q      <= lives_d;
            row_offset_q <= row_offset_d;
            key_latch_q  <= key_latch_d;
            wait_cnt_q   <= wait_cnt_d;
            hit_flags_q  <= hit_flags_d;
            miss_flag_q  <= miss_flag_d;
        end
    end

    assign clear_go   = (state_q == S_CLEAR);
    assign draw_go    = (state_q == S_DRAW);
    assign game_over  = (state_q == S_OVER);
    assign state_dbg  = state_q;
    assign score      = score_q;
    assign streak     = streak_q;
    assign lives      = lives_q;
    assign row_offset = row_offset_q;
    assign hit_flags  = hit_flags_q;
    assign miss_flag  = miss_flag_q;

endmodule

// File: tb/tb_lane_judge_ctrl.sv
// Directed bench for lane_judge_ctrl: a row-level game model drives per-cycle
// expectations, plus literal checkpoints and a free-play instance.
module tb_lane_judge_ctrl;

    localparam int LANES = 3;
    localparam int ROWS  = 8;
    localparam int ROWC  = 16;
    localparam int SCW   = 4;
    localparam int LIVES = 3;
    localparam int MAXV  = 15;

    logic clock;
    logic reset;
    logic start;
    logic clear_done;
    logic draw_done;
    logic [2:0] key;
    logic [2:0] note_row;

    logic       clear_go, draw_go, miss_flag, game_over;
    logic [2:0] row_offset, hit_flags, state_dbg;
    logic [3:0] score, streak;
    logic [1:0] lives;

    logic       fp_clear_go, fp_draw_go, fp_miss_flag, fp_game_over;
    logic [2:0] fp_row_offset, fp_hit_flags, fp_state_dbg;
    logic [3:0] fp_score, fp_streak;
    logic [1:0] fp_lives;

    lane_judge_ctrl #(.LANES(LANES), .ROWS(ROWS), .ROW_CYCLES(ROWC), .SCORE_W(SCW),
                      .LIVES(LIVES), .FREE_PLAY(0)) dut (
        .clock(clock), .reset(reset), .start(start), .clear_done(clear_done),
        .draw_done(draw_done), .key(key), .note_row(note_row),
        .clear_go(clear_go), .draw_go(draw_go), .row_offset(row_offset),
        .score(score), .streak(streak), .lives(lives), .hit_flags(hit_flags),
        .miss_flag(miss_flag), .game_over(game_over), .state_dbg(state_dbg)
    );

    lane_judge_ctrl #(.LANES(LANES), .ROWS(ROWS), .ROW_CYCLES(ROWC), .SCORE_W(SCW),
                      .LIVES(LIVES), .FREE_PLAY(1)) fp_dut (
        .clock(clock), .reset(reset), .start(start), .clear_done(clear_done),
        .draw_done(draw_done), .key(key), .note_row(note_row),
        .clear_go(fp_clear_go), .draw_go(fp_draw_go), .row_offset(fp_row_offset),
        .score(fp_score), .streak(fp_streak), .lives(fp_lives), .hit_flags(fp_hit_flags),
        .miss_flag(fp_miss_flag), .game_over(fp_game_over), .state_dbg(fp_state_dbg)
    );

    // ---------------- clock / reset ----------------
    initial clock = 1'b0;
    always #5 clock = ~clock;

    // ---------------- model state ----------------
    int         tests = 0;
    int         fails = 0;
    bit         check_en = 0;
    int         m_state, m_score, m_streak, m_lives, m_row;
    logic [2:0] m_carry, m_hit;
    logic       m_miss;
    logic [3:0] exp_q[$];

    int         cap_state, cap_score, cap_streak, cap_lives, cap_fp_lives;
    logic [2:0] cap_hit;
    logic       cap_miss, cap_fp_miss;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    function automatic int sat(input int v);
        return (v > MAXV) ? MAXV : v;
    endfunction

    // ---------------- driver tasks ----------------
    task automatic tick();
        @(posedge clock);
        #1;
        m_hit  = '0;
        m_miss = 1'b0;
    endtask

    task automatic model_load();
        m_score  = 0;
        m_streak = 0;
        m_lives  = LIVES;
        m_row    = 0;
        m_carry  = '0;
    endtask

    task automatic apply_reset();
        reset = 1'b0;
        tick();
        m_state = 0;
        model_load();
        check_en = 1;
        reset = 1'b1;
    endtask

    task automatic hold(input int n);
        for (int i = 0; i < n; i++) tick();
    endtask

    task automatic start_game();
        start = 1'b1;
        tick();
        m_state = 1;
        start = 1'b0;
    endtask

    task automatic do_clear(input int wait_cycles);
        for (int i = 0; i < wait_cycles; i++) begin
            tick();
            model_load();
        end
        clear_done = 1'b1;
        tick();
        model_load();
        m_state = 2;
        clear_done = 1'b0;
    endtask

    // Plays one row from the first DRAW cycle; ends in the next DRAW cycle, or in OVER.
    task automatic play_row(input logic [2:0] notes, input logic [2:0] kdraw,
                            input logic [2:0] kwait, input int kwait_cyc,
                            input logic [2:0] kadv, input int draw_wait);
        logic [2:0] latched;
        logic [2:0] hits;
        logic       bad;
        note_row = notes;
        key = kdraw;
        for (int i = 0; i < draw_wait; i++) tick();
        draw_done = 1'b1;
        tick();
        draw_done = 1'b0;
        m_state = 3;
        for (int c = 0; c < ROWC; c++) begin
            key = (c == kwait_cyc) ? kwait : 3'b000;
            tick();
            m_state = (c == ROWC - 1) ? 4 : 3;
        end
        key = 3'b000;
        latched = m_carry | kdraw | ((kwait_cyc >= 0 && kwait_cyc < ROWC) ? kwait : 3'b000);
        hits = latched & notes;
        bad  = (latched != notes);
        if ({bad, hits} != 4'b0000) exp_q.push_back({bad, hits});
        tick();
        if (!bad) begin
            m_score  = sat(m_score + $countones(hits));
            m_streak = sat(m_streak + 1);
        end else begin
            m_streak = 0;
            if (m_lives > 0) m_lives--;
        end
        m_hit   = hits;
        m_miss  = bad;
        m_state = (m_lives == 0) ? 6 : 5;
        cap_state    = state_dbg;
        cap_hit      = hit_flags;
        cap_miss     = miss_flag;
        cap_score    = score;
        cap_streak   = streak;
        cap_lives    = lives;
        cap_fp_miss  = fp_miss_flag;
        cap_fp_lives = fp_lives;
        if (m_state == 6) return;
        key = kadv;
        tick();
        m_state = 2;
        m_row   = (m_row == ROWS - 1) ? 0 : m_row + 1;
        m_carry = kadv;
        key = 3'b000;
    endtask

    // ---------------- per-cycle compare + pulse scoreboard ----------------
    always @(negedge clock) begin
        if (check_en) begin
            check("state_dbg", state_dbg, m_state);
            check("score", score, m_score);
            check("streak", streak, m_streak);
            check("lives", lives, m_lives);
            check("row_offset", row_offset, m_row);
            check("hit_flags", hit_flags, m_hit);
            check("miss_flag", miss_flag, m_miss);
            check("clear_go", clear_go, m_state == 1);
            check("draw_go", draw_go, m_state == 2);
            check("game_over", game_over, m_state == 6);
            check("fp_lives", fp_lives, LIVES);
            check("fp_game_over", fp_game_over, 0);
            if (hit_flags != 3'b000 || miss_flag) begin
                if (exp_q.size() == 0) check("pulse_unexpected", {miss_flag, hit_flags}, 0);
                else check("pulse_sb", {miss_flag, hit_flags}, exp_q.pop_front());
            end
        end
    end

    // ---------------- directed sequence ----------------
    initial begin
        reset = 1'b0; start = 1'b0; clear_done = 1'b0; draw_done = 1'b0;
        key = '0; note_row = '0;
        m_hit = '0; m_miss = 1'b0;
        apply_reset();
        check("rst_state", state_dbg, 0);
        check("rst_lives", lives, 3);
        check("rst_score", score, 0);

        clear_done = 1'b1; draw_done = 1'b1;
        hold(2);
        clear_done = 1'b0; draw_done = 1'b0;
        start_game();
        do_clear(2);

        play_row(3'b101, 3'b000, 3'b101, 5, 3'b000, 3);
        check("a_hit", cap_hit, 3'b101);
        check("a_miss", cap_miss, 0);
        check("a_score", cap_score, 2);
        check("a_streak", cap_streak, 1);
        check("a_lives", cap_lives, 3);

        play_row(3'b010, 3'b000, 3'b000, -1, 3'b000, 0);
        check("b_miss", cap_miss, 1);
        check("b_streak", cap_streak, 0);
        check("b_lives", cap_lives, 2);
        check("b_fp_miss", cap_fp_miss, 1);
        check("b_fp_lives", cap_fp_lives, 3);

        play_row(3'b000, 3'b000, 3'b010, 7, 3'b000, 1);
        check("c_miss", cap_miss, 1);
        check("c_lives", cap_lives, 1);

        play_row(3'b000, 3'b000, 3'b000, -1, 3'b000, 2);
        check("d_miss", cap_miss, 0);
        check("d_streak", cap_streak, 1);

        play_row(3'b011, 3'b001, 3'b010, 15, 3'b000, 0);
        play_row(3'b111, 3'b000, 3'b111, 0, 3'b000, 1);
        play_row(3'b100, 3'b000, 3'b100, 9, 3'b010, 0);
        check("g_row", row_offset, 7);
        play_row(3'b010, 3'b000, 3'b000, -1, 3'b000, 2);
        check("h_wrap", row_offset, 0);
        check("h_score", cap_score, 9);
        check("h_miss", cap_miss, 0);

        play_row(3'b111, 3'b111, 3'b000, -1, 3'b000, 0);
        play_row(3'b110, 3'b000, 3'b110, 3, 3'b000, 0);
        check("j_score", cap_score, 14);
        play_row(3'b111, 3'b000, 3'b111, 12, 3'b000, 1);
        check("k_score_sat", cap_score, 15);
        check("k_hit", cap_hit, 3'b111);
        check("k_streak", cap_streak, 8);

        play_row(3'b001, 3'b000, 3'b000, -1, 3'b000, 0);
        check("l_state_over", cap_state, 6);
        check("l_lives", cap_lives, 0);
        clear_done = 1'b1;
        hold(3);
        clear_done = 1'b0;

        start_game();
        do_clear(1);
        check("restart_lives", lives, 3);
        check("restart_score", score, 0);

        play_row(3'b101, 3'b101, 3'b000, -1, 3'b000, 0);
        play_row(3'b111, 3'b000, 3'b111, 2, 3'b000, 0);
        note_row = 3'b000;
        draw_done = 1'b1;
        tick();
        draw_done = 1'b0;
        m_state = 3;
        hold(4);
        check("pre_rst_score", score, 5);
        apply_reset();
        check("mid_rst_state", state_dbg, 0);
        check("mid_rst_score", score, 0);
        check("mid_rst_lives", lives, 3);
        check("mid_rst_clear_go", clear_go, 0);
        check("mid_rst_draw_go", draw_go, 0);
        hold(2);

        check_en = 0;
        check("sb_empty", exp_q.size(), 0);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
